// File: rtl/aes_pkg.sv
// Shared AES-128 constants, types and lookup tables for the key schedule.
// AES_BLOCK_SIZE normally comes from the project defines header; a fallback is provided here.
`ifndef AES_BLOCK_SIZE
`define AES_BLOCK_SIZE 128
`endif

package aes_pkg;

  localparam int AES_ROUNDS    = 10;
  localparam int AES_NUM_RKEYS = 11;
  localparam int AES_KEY_W     = `AES_BLOCK_SIZE;

  typedef logic [3:0] round_idx_t;

  typedef enum logic [1:0] {
    IDLE,
    EXPAND,
    DONE
  } ks_state_t;

  // Round constants, indexed by the round counter value 1..10
  localparam logic [1:10][7:0] RCON = {
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[b];
  endfunction

  function automatic logic [7:0] rcon_of(input round_idx_t i);
    if (i >= 4'd1 && i <= 4'd10) begin
      return RCON[i];
    end
    return 8'h00;
  endfunction

endpackage

// File: rtl/aes_key_expand_step.sv
// One AES-128 key expansion step: derives round key n from round key n-1 and its Rcon byte.
module aes_key_expand_step
  import aes_pkg::*;
(
  input  logic [AES_KEY_W-1:0] prev_key,
  input  logic [7:0]           rcon,
  output logic [AES_KEY_W-1:0] next_key
);

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] rot_w3, sub_w3;
  logic [31:0] n0, n1, n2, n3;

  assign {w0, w1, w2, w3} = prev_key;

  // RotWord moves the leading byte to the end before the S-box pass
  assign rot_w3 = {w3[23:0], w3[31:24]};
  assign sub_w3 = {sbox(rot_w3[31:24]), sbox(rot_w3[23:16]),
                   sbox(rot_w3[15:8]),  sbox(rot_w3[7:0])};

  assign n0 = w0 ^ sub_w3 ^ {rcon, 24'h000000};
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;

  assign next_key = {n0, n1, n2, n3};

endmodule

// File: rtl/aes_key_schedule_seq.sv
// Iterative AES-128 key schedule: one round key per clock into an 11-entry store.
// Optional AES_KEY_SCHED_ZEROIZE_EN adds a Zeroize input that wipes the store.
module aes_key_schedule_seq
  import aes_pkg::*;
(
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic [AES_KEY_W-1:0] Key_in,
  input  logic                 Key_valid,
  output logic                 Key_ready,
  output logic                 Keys_valid,
  input  logic                 Encrypt,
  input  round_idx_t           Round_idx,
`ifdef AES_KEY_SCHED_ZEROIZE_EN
  input  logic                 Zeroize,
`endif
  output logic [AES_KEY_W-1:0] Round_key
);

  ks_state_t           state, next_state;
  round_idx_t          cnt;
  round_idx_t          prev_idx;
  round_idx_t          rd_idx;
  logic [AES_KEY_W-1:0] store [AES_NUM_RKEYS];
  logic [AES_KEY_W-1:0] next_key;
  logic                 accept;

  assign accept = Key_valid && Key_ready;

  // cnt is 0 only in IDLE, where the step result is never stored
  assign prev_idx = (cnt == 4'd0) ? 4'd0 : cnt - 4'd1;

  aes_key_expand_step u_step (
    .prev_key (store[prev_idx]),
    .rcon     (rcon_of(cnt)),
    .next_key (next_key)
  );

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = EXPAND;
      EXPAND:  if (cnt == round_idx_t'(AES_ROUNDS)) next_state = DONE;
      DONE:    if (accept) next_state = EXPAND;
      default: next_state = IDLE;
    endcase
`ifdef AES_KEY_SCHED_ZEROIZE_EN
    if (Zeroize) next_state = IDLE;
`endif
  end

  always_comb begin
    Key_ready  = 1'b0;
    Keys_valid = 1'b0;
    case (state)
      IDLE:    Key_ready = 1'b1;
      DONE: begin
        Key_ready  = 1'b1;
        Keys_valid = 1'b1;
      end
      default: Key_ready = 1'b0;
    endcase
  end

  // Zeroize outranks a key presented on the same edge
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      cnt <= '0;
      for (int i = 0; i < AES_NUM_RKEYS; i++) store[i] <= '0;
    end else begin
`ifdef AES_KEY_SCHED_ZEROIZE_EN
      if (Zeroize) begin
        cnt <= '0;
        for (int i = 0; i < AES_NUM_RKEYS; i++) store[i] <= '0;
      end else
`endif
      if (accept) begin
        store[0] <= Key_in;
        cnt      <= 4'd1;
      end else if (state == EXPAND) begin
        store[cnt] <= next_key;
        cnt        <= cnt + 4'd1;
      end
    end
  end

  assign rd_idx = Encrypt ? Round_idx : round_idx_t'(AES_ROUNDS) - Round_idx;

  always_comb begin
    Round_key = '0;
    if (Round_idx <= round_idx_t'(AES_ROUNDS)) begin
      Round_key = store[rd_idx];
    end
  end

endmodule

// File: tb/tb_aes_key_schedule_seq.sv
// Directed self-checking bench for aes_key_schedule_seq using FIPS-197 key vectors.
module tb_aes_key_schedule_seq;
  import aes_pkg::*;

  logic         Clk;
  logic         Rst;
  logic [127:0] Key_in;
  logic         Key_valid;
  logic         Key_ready;
  logic         Keys_valid;
  logic         Encrypt;
  logic [3:0]   Round_idx;
  logic [127:0] Round_key;
`ifdef AES_KEY_SCHED_ZEROIZE_EN
  logic         Zeroize;
`endif

  int errorCount = 0;
  int checkCount = 0;

  localparam logic [127:0] KEY_A = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] KEY_B = 128'h000102030405060708090a0b0c0d0e0f;

  logic [127:0] schedA [11];

  aes_key_schedule_seq dut (
    .Clk        (Clk),
    .Rst        (Rst),
    .Key_in     (Key_in),
    .Key_valid  (Key_valid),
    .Key_ready  (Key_ready),
    .Keys_valid (Keys_valid),
    .Encrypt    (Encrypt),
    .Round_idx  (Round_idx),
`ifdef AES_KEY_SCHED_ZEROIZE_EN
    .Zeroize    (Zeroize),
`endif
    .Round_key  (Round_key)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    checkCount++;
    assert (observed === expected) else begin
      errorCount++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      $error("[TB] check %s did not hold", tag);
    end
  endtask

  task automatic checkRead(input string tag, input logic enc, input int idx, input logic [127:0] expected);
    Encrypt   = enc;
    Round_idx = 4'(idx);
    #1;
    checkOutput(tag, Round_key, expected);
  endtask

  // Presents a key for exactly one rising edge, leaving inputs idle 1 ns after it
  task automatic applyStimulus(input logic [127:0] key);
    Key_in    = key;
    Key_valid = 1'b1;
    @(posedge Clk);
    #1;
    Key_valid = 1'b0;
  endtask

  initial begin
    schedA = '{
      128'h2b7e151628aed2a6abf7158809cf4f3c,
      128'ha0fafe1788542cb123a339392a6c7605,
      128'hf2c295f27a96b9435935807a7359f67f,
      128'h3d80477d4716fe3e1e237e446d7a883b,
      128'hef44a541a8525b7fb671253bdb0bad00,
      128'hd4d1c6f87c839d87caf2b8bc11f915bc,
      128'h6d88a37a110b3efddbf98641ca0093fd,
      128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
      128'head27321b58dbad2312bf5607f8d292f,
      128'hac7766f319fadc2128d12941575c006e,
      128'hd014f9a8c9ee2589e13f0cc8b6630ca6
    };

    Rst       = 1'b1;
    Key_in    = '0;
    Key_valid = 1'b0;
    Encrypt   = 1'b1;
    Round_idx = 4'd0;
`ifdef AES_KEY_SCHED_ZEROIZE_EN
    Zeroize   = 1'b0;
`endif

    repeat (2) @(posedge Clk);
    #1;
    checkOutput("rst_key_ready", 128'(Key_ready), 128'd1);
    checkOutput("rst_keys_valid", 128'(Keys_valid), 128'd0);
    checkOutput("rst_round_key", Round_key, 128'd0);
    Rst = 1'b0;
    @(posedge Clk);
    #1;

    // Key A, with a different key pulsed mid-expansion that must be ignored
    applyStimulus(KEY_A);
    checkOutput("a_ready_expand", 128'(Key_ready), 128'd0);
    for (int i = 1; i <= 10; i++) begin
      if (i == 3) begin
        Key_in    = KEY_B;
        Key_valid = 1'b1;
      end
      if (i == 5) begin
        Key_in    = KEY_A;
        Key_valid = 1'b0;
      end
      @(posedge Clk);
      #1;
      checkOutput($sformatf("a_keys_valid_c%0d", i), 128'(Keys_valid), 128'(i == 10));
    end
    checkOutput("a_ready_done", 128'(Key_ready), 128'd1);

    for (int i = 0; i <= 10; i++) checkRead($sformatf("a_enc_idx%0d", i), 1'b1, i, schedA[i]);
    for (int i = 0; i <= 10; i++) checkRead($sformatf("a_dec_idx%0d", i), 1'b0, i, schedA[10 - i]);
    for (int i = 11; i <= 15; i++) begin
      checkRead($sformatf("a_enc_oob%0d", i), 1'b1, i, 128'd0);
      checkRead($sformatf("a_dec_oob%0d", i), 1'b0, i, 128'd0);
    end

    // Key B accepted straight from DONE
    @(posedge Clk);
    #1;
    applyStimulus(KEY_B);
    checkOutput("b_keys_valid_drop", 128'(Keys_valid), 128'd0);
    checkOutput("b_ready_expand", 128'(Key_ready), 128'd0);
    for (int i = 1; i <= 10; i++) begin
      @(posedge Clk);
      #1;
      checkOutput($sformatf("b_keys_valid_c%0d", i), 128'(Keys_valid), 128'(i == 10));
    end
    checkRead("b_enc_idx0", 1'b1, 0, KEY_B);
    checkRead("b_enc_idx1", 1'b1, 1, 128'hd6aa74fdd2af72fadaa678f1d6ab76fe);
    checkRead("b_enc_idx10", 1'b1, 10, 128'h13111d7fe3944a17f307a78b4d2b30c5);
    checkRead("b_dec_idx0", 1'b0, 0, 128'h13111d7fe3944a17f307a78b4d2b30c5);
    checkRead("b_dec_idx10", 1'b0, 10, KEY_B);

    // Reset asserted five cycles into an expansion
    @(posedge Clk);
    #1;
    applyStimulus(KEY_A);
    repeat (5) @(posedge Clk);
    #1;
    Rst = 1'b1;
    #1;
    checkOutput("mid_rst_key_ready", 128'(Key_ready), 128'd1);
    checkOutput("mid_rst_keys_valid", 128'(Keys_valid), 128'd0);
    checkRead("mid_rst_idx0", 1'b1, 0, 128'd0);
    checkRead("mid_rst_idx3", 1'b1, 3, 128'd0);
    @(posedge Clk);
    #1;
    Rst = 1'b0;
    @(posedge Clk);
    #1;
    checkOutput("post_rst_keys_valid", 128'(Keys_valid), 128'd0);

    applyStimulus(KEY_A);
    for (int i = 1; i <= 10; i++) begin
      @(posedge Clk);
      #1;
      checkOutput($sformatf("r_keys_valid_c%0d", i), 128'(Keys_valid), 128'(i == 10));
    end
    checkRead("r_enc_idx1", 1'b1, 1, schedA[1]);
    checkRead("r_enc_idx10", 1'b1, 10, schedA[10]);
    checkRead("r_dec_idx0", 1'b0, 0, schedA[10]);

`ifdef AES_KEY_SCHED_ZEROIZE_EN
    // Zeroize and a new key on the same DONE edge: zeroize wins
    @(posedge Clk);
    #1;
    Zeroize = 1'b1;
    applyStimulus(KEY_B);
    Zeroize = 1'b0;
    checkOutput("z_key_ready", 128'(Key_ready), 128'd1);
    checkOutput("z_keys_valid", 128'(Keys_valid), 128'd0);
    for (int i = 0; i <= 10; i++) checkRead($sformatf("z_idx%0d", i), 1'b1, i, 128'd0);
    @(posedge Clk);
    #1;
    checkOutput("z_stays_idle", 128'(Keys_valid), 128'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule

// File: doc/aes_key_schedule_seq.md
# aes_key_schedule_seq

Iterative AES-128 key expansion unit. Accepts a 128-bit cipher key over a valid/ready handshake and computes one round key per clock into an 11-entry key store. Once expansion completes it serves round keys combinationally to the downstream round datapath through its `Key` input, selected by logical round index. For decryption the read order is reversed, so the round controller indexes rounds 0..10 identically in both directions.

## Interface
- No parameters; AES-128 only. Round count and key width come from the shared package.
- `Clk  input  1` — single clock; all state updates on the rising edge.
- `Rst  input  1` — asynchronous, active-high reset.
- `Key_in  input  128` — cipher key; byte 0 at [127:120].
- `Key_valid  input  1` — `Key_in` is presented.
- `Key_ready  output  1` — block can accept a key.
- `Keys_valid  output  1` — all 11 round keys are stored and readable.
- `Encrypt  input  1` — 1 selects forward read order, 0 selects reverse.
- `Round_idx  input  4` — logical round 0..10.
- `Round_key  output  128` — selected round key, combinational from the store.
- `Zeroize  input  1` — present only with the configuration macro.

## Operation
- FSM states: IDLE, EXPAND, DONE.
- Acceptance: `Key_valid && Key_ready` is sampled on an edge.
  - The key is written to store[0], the round counter is set to 1, and the FSM enters EXPAND.
- EXPAND: each edge writes `store[cnt] = step(store[cnt-1], rcon[cnt])`, then increments `cnt`.
  - The edge that writes store[10] moves the FSM to DONE.
- `step` performs the standard AES-128 expansion:
  - `w0' = w0 ^ SubWord(RotWord(w3)) ^ {rcon,24'h0}`
  - `w1' = w1 ^ w0'`
  - `w2' = w2 ^ w1'`
  - `w3' = w3 ^ w2'`
- `Key_ready` is 1 in IDLE and DONE, and 0 in EXPAND. `Key_valid` during EXPAND is ignored.
- Key arriving in DONE: accepted, and expansion restarts.
  - `Keys_valid` falls on the same edge.
  - Store entries 1..10 hold stale data until overwritten; consumers must not read while `Keys_valid` is 0.
- `Keys_valid` is 1 only in DONE.
- Read port:
  - `Round_key = Encrypt ? store[Round_idx] : store[10-Round_idx]`.
  - `Round_idx` > 10 returns all zeros.
  - The read is valid in any state, but its content is defined only while `Keys_valid` is 1.

## Timing
- Reset values: FSM = IDLE, `cnt` = 0, store cleared to zero, `Key_ready` = 1, `Keys_valid` = 0, `Round_key` = 0.
- Latency: a key accepted at edge E0 produces `Keys_valid` = 1 immediately after edge E10, i.e. 10 cycles.
- Throughput: one new key per 11 cycles; back-to-back acceptance is allowed from DONE.
- `Round_key` follows `Round_idx` and `Encrypt` with zero cycle latency (pure mux). The downstream combinational round sees it in the same cycle.
- Reset asserted mid-EXPAND: immediate abort, everything returns to reset values, and the partial key is discarded.
- Rcon sequence for counts 1..10: 01 02 04 08 10 20 40 80 1B 36.

## Configuration
- `AES_KEY_SCHED_ZEROIZE_EN` defined:
  - Adds the `Zeroize` input port.
  - `Zeroize` sampled high on an edge clears the store and `cnt`, and forces IDLE.
  - It takes priority over key acceptance in the same cycle; `Keys_valid` = 0 after that edge.
- Macro undefined: the port is absent, and key material persists until overwritten or reset.

## Structure
- `aes_pkg` holds:
  - `AES_ROUNDS` = 10
  - `AES_NUM_RKEYS` = 11
  - the Rcon byte table indexed 1..10
  - the FSM state enum
  - the 4-bit round-index typedef
- `AES_BLOCK_SIZE` comes from the existing defines header.
- One sub-module, `aes_key_expand_step`: combinational, with inputs previous key (128) and rcon (8), and output next key (128).
  - It contains the four S-box lookups for SubWord.
  - The FSM, counter and store stay in the top module.

## Test plan
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, held until accepted:
  - `Keys_valid` rises exactly 10 cycles after acceptance.
  - With `Encrypt` = 1: idx 1 returns a0fafe1788542cb123a339392a6c7605, idx 10 returns d014f9a8c9ee2589e13f0cc8b6630ca6.
- Same key with `Encrypt` = 0: idx 0 returns d014f9a8…0ca6 and idx 10 returns 2b7e1516…4f3c. Idx 11..15 return zero in both modes.
- `Key_valid` pulsed during EXPAND with a different key: ignored, and the result still matches the first key.
- Key B accepted in DONE: `Keys_valid` drops the next cycle and returns 10 cycles later with B's schedule.
- `Rst` asserted at cycle 5 of EXPAND:
  - Outputs are at reset values immediately.
  - A later full expansion completes correctly.
- With `AES_KEY_SCHED_ZEROIZE_EN`: `Zeroize` and `Key_valid` high in DONE in the same cycle leave IDLE, `Keys_valid` = 0, and all reads zero.
